pwm_gen_mc: RTL

//  Multi-channel PWM generator for the visual cortex LED drivers, successor to the fixed-period PWM generator.

---
 rtl/syn_pwm_pkg.sv | 18 +
 rtl/pwm_chan_cmp.sv | 80 ++++++++
 rtl/pwm_gen_mc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/syn_pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode and direction
// encodings, default field width and the duty-slice helper.
package syn_pwm_pkg;

   localparam logic       PWM_MODE_EDGE   = 1'b0;
   localparam logic       PWM_MODE_CENTER = 1'b1;

   localparam logic [0:0] DIR_UP   = 1'b0;
   localparam logic [0:0] DIR_DOWN = 1'b1;

   localparam int         PWM_RES_DEFAULT = 16;

   // LSB of channel ch inside the packed duty vector
   function automatic int duty_lsb(input int ch, input int res);
      return ch * res;
   endfunction

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM channel: duty compare and registered pin; with PWM_SOFT_START_EN
// defined, a running duty ramps toward the target once per period.
module pwm_chan_cmp
   import syn_pwm_pkg::*;
#(
   parameter int   P_RES        = PWM_RES_DEFAULT,
   parameter logic P_LED_ON_VAL = 1'b1,
   parameter int   P_RAMP_STEP  = 1
) (
   input  logic             clk_ir,
   input  logic             rst_il,
   input  logic             pwm_en_ih,
   input  logic             period_end_ih,
   input  logic [P_RES-1:0] cntr_id,
   input  logic [P_RES-1:0] duty_act_id,
   input  logic [P_RES-1:0] duty_tgt_id,
   output logic             pin_oh
);

   localparam logic [P_RES-1:0] RAMP_STEP_C = P_RES'(P_RAMP_STEP);

   logic [P_RES-1:0] duty_cmp;
   logic             pin_reg;
   logic             pin_next;
   logic             unused_sig;

`ifdef PWM_SOFT_START_EN
   logic [P_RES-1:0] run_reg;
   logic [P_RES-1:0] run_next;

   // Target is the value active will hold after this clock, so a commit on
   // the same period_end already steers the first ramp step.
   always_comb begin
      run_next = run_reg;
      if (!pwm_en_ih) begin
         run_next = '0;
      end else if (period_end_ih) begin
         if (run_reg < duty_tgt_id) begin
            run_next = ((duty_tgt_id - run_reg) > RAMP_STEP_C) ?
                       (run_reg + RAMP_STEP_C) : duty_tgt_id;
         end else if (run_reg > duty_tgt_id) begin
            run_next = ((run_reg - duty_tgt_id) > RAMP_STEP_C) ?
                       (run_reg - RAMP_STEP_C) : duty_tgt_id;
         end
      end
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         run_reg <= '0;
      end else begin
         run_reg <= run_next;
      end
   end

   assign duty_cmp   = run_reg;
   assign unused_sig = ^duty_act_id;
`else
   assign duty_cmp   = duty_act_id;
   assign unused_sig = ^{duty_tgt_id, period_end_ih, RAMP_STEP_C};
`endif

   always_comb begin
      pin_next = ~P_LED_ON_VAL;
      if (pwm_en_ih && (cntr_id < duty_cmp)) begin
         pin_next = P_LED_ON_VAL;
      end
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         pin_reg <= ~P_LED_ON_VAL;
      end else begin
         pin_reg <= pin_next;
      end
   end

   assign pin_oh = pin_reg;

endmodule

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: counter/direction FSM, shadowed duty/period/mode
// with valid/ready load, period-boundary commit. Optional PWM_SOFT_START_EN.
module pwm_gen_mc
   import syn_pwm_pkg::*;
#(
   parameter int   P_NO_CHANNELS    = 16,
   parameter int   P_PWM_RESOLUTION = PWM_RES_DEFAULT,
   parameter logic P_LED_ON_VAL     = 1'b1,
   parameter int   P_RAMP_STEP      = 1
) (
   input  logic                                  clk_ir,
   input  logic                                  rst_il,
   input  logic                                  pwm_en_ih,
   input  logic                                  pwm_load_ih,
   output logic                                  pwm_load_rdy_oh,
   input  logic [P_NO_CHANNELS*P_PWM_RESOLUTION-1:0] pwm_on_vec_id,
   input  logic [P_PWM_RESOLUTION-1:0]           pwm_period_id,
   input  logic                                  pwm_mode_ih,
   output logic                                  pwm_commit_oh,
   output logic                                  pwm_refresh_oh,
   output logic [P_NO_CHANNELS-1:0]              pwm_data_od
);

   localparam int RES = P_PWM_RESOLUTION;
   localparam int VW  = P_NO_CHANNELS * P_PWM_RESOLUTION;

   logic [RES-1:0] cntr_reg,       cntr_next;
   logic [0:0]     dir_reg,        dir_next;
   logic [VW-1:0]  act_vec_reg,    sh_vec_reg;
   logic [RES-1:0] act_period_reg, sh_period_reg;
   logic           act_mode_reg,   sh_mode_reg;
   logic           pending_reg;
   logic           refresh_reg;

   logic           period_end;
   logic           accept;
   logic           commit;
   logic           mode_chg;
   logic [VW-1:0]  duty_tgt_vec;

   always_comb begin
      period_end = (cntr_reg == act_period_reg);
      if (act_mode_reg == PWM_MODE_CENTER) begin
         period_end = (act_period_reg == '0) ||
                      ((dir_reg == DIR_DOWN) && (cntr_reg == '0));
      end
   end

   assign accept   = pwm_load_ih && !pending_reg;
   assign commit   = pending_reg && (period_end || !pwm_en_ih);
   assign mode_chg = commit && (sh_mode_reg != act_mode_reg);

   // Center mode turns at the top without repeating the peak, and the
   // down-count zero doubles as the first clock of the next period.
   always_comb begin
      cntr_next = cntr_reg;
      dir_next  = dir_reg;
      if (!pwm_en_ih || mode_chg) begin
         cntr_next = '0;
         dir_next  = DIR_UP;
      end else if (act_mode_reg == PWM_MODE_EDGE) begin
         cntr_next = period_end ? '0 : (cntr_reg + 1'b1);
         dir_next  = DIR_UP;
      end else if (act_period_reg == '0) begin
         cntr_next = '0;
         dir_next  = DIR_UP;
      end else if (dir_reg == DIR_UP) begin
         if (cntr_reg >= act_period_reg) begin
            cntr_next = act_period_reg - 1'b1;
            dir_next  = DIR_DOWN;
         end else begin
            cntr_next = cntr_reg + 1'b1;
         end
      end else begin
         if (cntr_reg == '0) begin
            cntr_next = {{(RES-1){1'b0}}, 1'b1};
            dir_next  = DIR_UP;
         end else begin
            cntr_next = cntr_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         cntr_reg    <= '0;
         dir_reg     <= DIR_UP;
         refresh_reg <= 1'b0;
      end else begin
         cntr_reg    <= cntr_next;
         dir_reg     <= dir_next;
         refresh_reg <= pwm_en_ih && period_end;
      end
   end

   // Shadow and active register banks; accept and commit are exclusive.
   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         sh_vec_reg     <= '0;
         sh_period_reg  <= '1;
         sh_mode_reg    <= PWM_MODE_EDGE;
         act_vec_reg    <= '0;
         act_period_reg <= '1;
         act_mode_reg   <= PWM_MODE_EDGE;
         pending_reg    <= 1'b0;
      end else begin
         if (accept) begin
            sh_vec_reg    <= pwm_on_vec_id;
            sh_period_reg <= pwm_period_id;
            sh_mode_reg   <= pwm_mode_ih;
            pending_reg   <= 1'b1;
         end else if (commit) begin
            act_vec_reg    <= sh_vec_reg;
            act_period_reg <= sh_period_reg;
            act_mode_reg   <= sh_mode_reg;
            pending_reg    <= 1'b0;
         end
      end
   end

   assign duty_tgt_vec = commit ? sh_vec_reg : act_vec_reg;

   genvar gi;
   generate
      for (gi = 0; gi < P_NO_CHANNELS; gi = gi + 1) begin : g_chan
         localparam int LSB = duty_lsb(gi, RES);
         pwm_chan_cmp #(
            .P_RES        (RES),
            .P_LED_ON_VAL (P_LED_ON_VAL),
            .P_RAMP_STEP  (P_RAMP_STEP)
         ) u_chan (
            .clk_ir        (clk_ir),
            .rst_il        (rst_il),
            .pwm_en_ih     (pwm_en_ih),
            .period_end_ih (period_end),
            .cntr_id       (cntr_reg),
            .duty_act_id   (act_vec_reg[LSB +: RES]),
            .duty_tgt_id   (duty_tgt_vec[LSB +: RES]),
            .pin_oh        (pwm_data_od[gi])
         );
      end
   endgenerate

   assign pwm_load_rdy_oh = !pending_reg;
   assign pwm_commit_oh   = commit;
   assign pwm_refresh_oh  = refresh_reg;

endmodule
